// File: rtl/fsm_step_arbiter.sv
// Round-robin arbiter that steps a shared 2-bit control FSM, one ctrl pulse at a time,
// until its Y output matches the granted requester's target; reports done, or err on step-budget exhaustion.
module fsm_step_arbiter #(
  parameter int MAX_STEPS = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] tgt0,
  input  logic [1:0] tgt1,
  input  logic [1:0] y_in,
  output logic       ctrl_out,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, CHECK, STEP, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

  state_t             state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         tgt_q, tgt_d;
  logic               ctrl_q, ctrl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 2'b00;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= 2'b00;
      ctrl_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    sel     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          // Contention goes to the round-robin pointer; otherwise whoever is asking.
          sel     = (req == 2'b11) ? rr_q : req[1];
          gnt_d   = sel ? 2'b10 : 2'b01;
          tgt_d   = sel ? tgt1 : tgt0;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (y_in == tgt_q) begin
          done_d  = 1'b1;
          state_d = RESP;
        end else begin
          state_d = STEP;
        end
      end
      STEP: begin
        cnt_d   = (cnt_q >= MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        // Compare before issuing another pulse so the FSM never overshoots.
        if (y_in == tgt_q) begin
          done_d  = 1'b1;
          state_d = RESP;
        end else if (cnt_q >= MAX_CNT) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = STEP;
        end
      end
      RESP: begin
        rr_d    = gnt_q[0];
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they switch cleanly with the state.
    ctrl_d = (state_d == STEP);
    busy_d = (state_d != IDLE);
  end

  assign ctrl_out = ctrl_q;
  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fsm_step_arbiter.sv
// Directed bench for fsm_step_arbiter; the FSM is modelled as a 2-bit counter advanced by ctrl.
module tb_fsm_step_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [1:0] tgt0;
  logic [1:0] tgt1;
  logic [1:0] y_in;
  logic       ctrl_out;
  logic [1:0] gnt;
  logic       busy;
  logic       done;
  logic       err;

  logic       y_load;
  logic [1:0] y_load_val;
  logic       stuck;

  int checks = 0;
  int errors = 0;

  logic       ctrl_h [0:31];
  logic       busy_h [0:31];
  logic       done_h [0:31];
  logic       err_h  [0:31];
  logic [1:0] gnt_h  [0:31];
  logic [1:0] y_h    [0:31];

  fsm_step_arbiter #(.MAX_STEPS(4), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .tgt0     (tgt0),
    .tgt1     (tgt1),
    .y_in     (y_in),
    .ctrl_out (ctrl_out),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // FSM model: Y advances on edges where ctrl is high, unless stuck.
  always @(posedge clk) begin
    if (y_load)
      y_in <= y_load_val;
    else if (ctrl_out && !stuck)
      y_in <= y_in + 2'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input logic [1:0] v);
    y_load_val = v;
    y_load     = 1'b1;
    tick();
    y_load     = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Cycle 0 is the IDLE cycle in which req is first seen; req drops and targets flip at drop_at.
  task automatic run(input int ncyc, input int drop_at);
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) tick();
      ctrl_h[c] = ctrl_out;
      busy_h[c] = busy;
      done_h[c] = done;
      err_h[c]  = err;
      gnt_h[c]  = gnt;
      y_h[c]    = y_in;
      if (c == drop_at) begin
        req  = 2'b00;
        tgt0 = tgt0 ^ 2'b11;
        tgt1 = tgt1 ^ 2'b11;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({ctrl_out, gnt, busy, done, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000", {ctrl_out, gnt, busy, done, err});
    end
    tick();
    reset = 1'b0;
    set_y(2'b00);
  endtask

  task automatic test_target_met();
    int pulses;
    set_y(2'b10);
    tgt0 = 2'b10;
    req  = 2'b01;
    run(4, 1);
    checks++;
    if (gnt_h[1] !== 2'b01) begin errors++; $display("FAIL met_gnt c1 got %b exp 01", gnt_h[1]); end
    checks++;
    if (done_h[2] !== 1'b1 || done_h[1] !== 1'b0 || done_h[3] !== 1'b0) begin
      errors++; $display("FAIL met_done got c1=%b c2=%b c3=%b exp 010", done_h[1], done_h[2], done_h[3]);
    end
    pulses = 0;
    for (int c = 0; c <= 4; c++) pulses += int'(ctrl_h[c]);
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL met_ctrl pulses got %0d exp 0", pulses); end
    checks++;
    if (busy_h[3] !== 1'b0 || busy_h[1] !== 1'b1) begin
      errors++; $display("FAIL met_busy got c1=%b c3=%b exp 1 0", busy_h[1], busy_h[3]);
    end
  endtask

  task automatic test_two_steps();
    int pulses;
    set_y(2'b00);
    tgt0 = 2'b10;
    req  = 2'b01;
    run(8, 1);
    pulses = 0;
    for (int c = 0; c <= 8; c++) pulses += int'(ctrl_h[c]);
    checks++;
    if (ctrl_h[2] !== 1'b1 || ctrl_h[4] !== 1'b1 || pulses != 2) begin
      errors++; $display("FAIL two_ctrl got c2=%b c4=%b total=%0d exp 1 1 2", ctrl_h[2], ctrl_h[4], pulses);
    end
    checks++;
    if (y_h[5] !== 2'b10) begin errors++; $display("FAIL two_y c5 got %b exp 10", y_h[5]); end
    checks++;
    if (done_h[6] !== 1'b1 || done_h[5] !== 1'b0 || err_h[6] !== 1'b0) begin
      errors++; $display("FAIL two_done got done5=%b done6=%b err6=%b exp 0 1 0", done_h[5], done_h[6], err_h[6]);
    end
    checks++;
    if (gnt_h[6] !== 2'b01 || gnt_h[7] !== 2'b00) begin
      errors++; $display("FAIL two_gnt got c6=%b c7=%b exp 01 00", gnt_h[6], gnt_h[7]);
    end
  endtask

  task automatic test_simultaneous();
    int pulses;
    apply_reset();
    set_y(2'b00);
    tgt0 = 2'b01;
    tgt1 = 2'b11;
    req  = 2'b11;
    run(13, 11);
    checks++;
    if (gnt_h[1] !== 2'b01) begin errors++; $display("FAIL sim_first_gnt got %b exp 01", gnt_h[1]); end
    checks++;
    if (done_h[4] !== 1'b1) begin errors++; $display("FAIL sim_first_done c4 got %b exp 1", done_h[4]); end
    checks++;
    if (gnt_h[5] !== 2'b00 || busy_h[5] !== 1'b0) begin
      errors++; $display("FAIL sim_gap got gnt=%b busy=%b exp 00 0", gnt_h[5], busy_h[5]);
    end
    checks++;
    if (gnt_h[6] !== 2'b10) begin errors++; $display("FAIL sim_second_gnt got %b exp 10", gnt_h[6]); end
    checks++;
    if (done_h[11] !== 1'b1 || done_h[10] !== 1'b0 || gnt_h[11] !== 2'b10) begin
      errors++; $display("FAIL sim_second_done got d10=%b d11=%b gnt11=%b exp 0 1 10", done_h[10], done_h[11], gnt_h[11]);
    end
    pulses = 0;
    for (int c = 0; c <= 13; c++) pulses += int'(ctrl_h[c]);
    checks++;
    if (ctrl_h[2] !== 1'b1 || ctrl_h[7] !== 1'b1 || ctrl_h[9] !== 1'b1 || pulses != 3) begin
      errors++; $display("FAIL sim_ctrl got c2=%b c7=%b c9=%b total=%0d exp 1 1 1 3", ctrl_h[2], ctrl_h[7], ctrl_h[9], pulses);
    end
    checks++;
    if (gnt_h[12] !== 2'b00 || busy_h[13] !== 1'b0) begin
      errors++; $display("FAIL sim_end got gnt12=%b busy13=%b exp 00 0", gnt_h[12], busy_h[13]);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    int dones;
    int errs;
    int consec;
    stuck = 1'b1;
    set_y(2'b00);
    tgt0 = 2'b11;
    req  = 2'b01;
    run(12, 1);
    pulses = 0;
    dones  = 0;
    errs   = 0;
    consec = 0;
    for (int c = 0; c <= 12; c++) begin
      pulses += int'(ctrl_h[c]);
      dones  += int'(done_h[c]);
      errs   += int'(err_h[c]);
      if (c > 0 && ctrl_h[c] === 1'b1 && ctrl_h[c-1] === 1'b1) consec++;
    end
    checks++;
    if (pulses != 4 || ctrl_h[8] !== 1'b1) begin
      errors++; $display("FAIL to_pulses got %0d c8=%b exp 4 1", pulses, ctrl_h[8]);
    end
    checks++;
    if (err_h[10] !== 1'b1 || errs != 1) begin
      errors++; $display("FAIL to_err got c10=%b total=%0d exp 1 1", err_h[10], errs);
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL to_no_done got %0d exp 0", dones); end
    checks++;
    if (consec != 0) begin errors++; $display("FAIL to_ctrl_consec got %0d exp 0", consec); end
    checks++;
    if (busy_h[11] !== 1'b0) begin errors++; $display("FAIL to_busy c11 got %b exp 0", busy_h[11]); end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_service();
    int flags;
    set_y(2'b00);
    tgt0 = 2'b11;
    req  = 2'b01;
    tick();
    tick();
    checks++;
    if (ctrl_out !== 1'b1) begin errors++; $display("FAIL mid_step_ctrl got %b exp 1", ctrl_out); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ctrl_out, gnt, busy, done, err} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %b exp 000000", {ctrl_out, gnt, busy, done, err});
    end
    req = 2'b00;
    tick();
    reset = 1'b0;
    flags = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      flags += int'(done) + int'(err) + int'(busy);
    end
    checks++;
    if (flags != 0) begin errors++; $display("FAIL mid_no_resp got %0d exp 0", flags); end
    set_y(2'b00);
    tgt0 = 2'b00;
    tgt1 = 2'b01;
    req  = 2'b11;
    run(4, 1);
    checks++;
    if (gnt_h[1] !== 2'b01) begin errors++; $display("FAIL mid_after_gnt got %b exp 01", gnt_h[1]); end
    checks++;
    if (done_h[2] !== 1'b1 || ctrl_h[2] !== 1'b0) begin
      errors++; $display("FAIL mid_after_done got done=%b ctrl=%b exp 1 0", done_h[2], ctrl_h[2]);
    end
  endtask

  initial begin
    req        = 2'b00;
    tgt0       = 2'b00;
    tgt1       = 2'b00;
    y_load     = 1'b0;
    y_load_val = 2'b00;
    stuck      = 1'b0;
    test_reset();
    test_target_met();
    test_two_steps();
    test_simultaneous();
    test_timeout();
    test_reset_mid_service();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
